booth_seq_mult: RTL and testbench

//  Sequential radix-4 Booth multiplier controller. Accepts one signed operand pair, walks the

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_pp_sel.sv | 41 ++++
 rtl/booth_seq_mult.sv | 128 ++++++++++++
 tb/tb_booth_seq_mult.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared definitions for the sequential radix-4 Booth multiplier:
//            FSM state encoding, 3-bit Booth window codes and the digit-count
//            helper.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Booth window codes {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] D_ZERO_P = 3'b000;
    localparam logic [2:0] D_PA0    = 3'b001;
    localparam logic [2:0] D_PA1    = 3'b010;
    localparam logic [2:0] D_P2A    = 3'b011;
    localparam logic [2:0] D_M2A    = 3'b100;
    localparam logic [2:0] D_MA0    = 3'b101;
    localparam logic [2:0] D_MA1    = 3'b110;
    localparam logic [2:0] D_ZERO_N = 3'b111;

    // Number of radix-4 digits needed to cover a W-bit signed multiplier
    function automatic int calc_ndig(input int w);
        return (w + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_sel.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_sel
// Purpose  : Combinational radix-4 Booth partial-product selector.
//            Maps a 3-bit multiplier window to 0, +-A or +-2A.
// Ports    : i_win [2:0]   Booth window
//            i_a   [W-1:0] multiplicand, signed
//            o_pp  [W+1:0] selected partial product, signed
// Revision : 1.0 - initial release
// ============================================================================
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int W = 25
) (
    input  logic [2:0]   i_win,
    input  logic [W-1:0] i_a,
    output logic [W+1:0] o_pp
);

    // Two extra bits: -2A with A = -2^(W-1) is +2^W and must stay positive.
    logic [W+1:0] w_a1;
    logic [W+1:0] w_a2;

    assign w_a1 = {{2{i_a[W-1]}}, i_a};
    assign w_a2 = {i_a[W-1], i_a, 1'b0};

    always_comb begin
        o_pp = '0;
        case (i_win)
            D_ZERO_P, D_ZERO_N: o_pp = '0;
            D_PA0, D_PA1:       o_pp = w_a1;
            D_P2A:              o_pp = w_a2;
            D_M2A:              o_pp = -w_a2;
            D_MA0, D_MA1:       o_pp = -w_a1;
            default:            o_pp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_mult
// Purpose  : Sequential radix-4 Booth multiplier. Accepts one signed operand
//            pair, retires one Booth digit per cycle into an accumulator and
//            returns the full-width signed product.
// Ports    : clk, rst (sync, active high)
//            in_valid/in_ready/in_a/in_b    operand handshake
//            out_valid/out_ready/out_p      product handshake (held until ready)
//            busy                           high while an operation is open
// Config   : BOOTH_EARLY_TERM_EN - stop as soon as the remaining multiplier
//            digits are all zero (data-dependent latency, same product).
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int W = 25
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    localparam int NDIG = calc_ndig(W);
    localparam int IW   = $clog2(NDIG);
    localparam int MW   = 2 * NDIG + 1;   // multiplier register incl. implicit b[-1]
    localparam int AW   = 2 * W + 2;      // accumulator width
    localparam int PW   = W + 2;          // partial product width

    localparam logic [IW-1:0] c_LAST_IDX = IW'(NDIG - 1);
    localparam logic [IW-1:0] c_ONE      = IW'(1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [MW-1:0] r_mul;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_acc;

    logic [IW:0]   w_bit0;
    logic [2:0]    w_win;
    logic [PW-1:0] w_pp;
    logic [AW-1:0] w_pp_ext;
    logic [AW-1:0] w_pp_sh;
    logic          w_last;
    logic          w_done;

    // Window for digit idx starts at bit 2*idx of the {b, 1'b0} register.
    assign w_bit0 = {r_idx, 1'b0};
    assign w_win  = r_mul[w_bit0 +: 3];

    booth_pp_sel #(
        .W (W)
    ) u_pp_sel (
        .i_win (w_win),
        .i_a   (r_a),
        .o_pp  (w_pp)
    );

    assign w_pp_ext = {{(AW-PW){w_pp[PW-1]}}, w_pp};
    assign w_pp_sh  = w_pp_ext << w_bit0;
    assign w_last   = (r_idx == c_LAST_IDX);

`ifdef BOOTH_EARLY_TERM_EN
    // Digits above idx are all zero once every bit from the next window's
    // base upward equals the sign bit; an arithmetic shift exposes that.
    localparam logic [IW:0] c_TWO = (IW+1)'(2);

    logic [IW:0]   w_next_bit;
    logic [MW-1:0] w_rest;

    assign w_next_bit = w_bit0 + c_TWO;
    assign w_rest     = $signed(r_mul) >>> w_next_bit;
    assign w_done     = w_last || (w_rest == {MW{r_mul[MW-1]}});
`else
    assign w_done     = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_mul   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_mul   <= {{(MW-1-W){in_b[W-1]}}, in_b, 1'b0};
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= r_acc + w_pp_sh;
                    r_idx <= r_idx + c_ONE;
                    if (w_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The accumulator carries two guard bits; the product always fits in 2W.
    assign out_p     = r_acc[2*W-1:0];
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_mult
// Purpose  : Self-checking bench for booth_seq_mult. Stimulus pushes expected
//            products and latencies into a queue; a monitor pops and compares
//            on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mult;

    localparam int W    = 25;
    localparam int NDIG = 13;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    always #5 clk = ~clk;

    booth_seq_mult #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    typedef struct {
        longint p;
        int     lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors   = 0;
    int   checks   = 0;
    int   ncyc     = 0;
    int   acc_time = 0;

    // out_ready source: 0 = always high, 1 = random, 2 = manual
    int   rdy_mode  = 0;
    logic man_ready = 1'b1;
    logic rnd_ready = 1'b1;
    assign out_ready = (rdy_mode == 2) ? man_ready : ((rdy_mode == 1) ? rnd_ready : 1'b1);

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 1) == 1);
    end

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: plain signed product
    function automatic longint model_prod(input longint a, input longint b);
        return a * b;
    endfunction

    // Reference latency (accept -> out_valid). With early termination the
    // block needs k digits where k is the smallest count such that b fits in
    // a 2k-bit signed number.
    function automatic int model_lat(input longint b);
        int lat;
        lat = NDIG + 1;
`ifdef BOOTH_EARLY_TERM_EN
        for (int k = NDIG; k >= 1; k--) begin
            longint lim;
            lim = longint'(1) <<< (2 * k - 1);
            if (b >= -lim && b < lim) lat = k + 1;
        end
`else
        if (b == 0) lat = NDIG + 1;
`endif
        return lat;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic           prev_ov = 1'b0;
    logic           prev_or = 1'b0;
    logic [2*W-1:0] prev_p  = '0;

    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (in_valid && in_ready) acc_time = ncyc;
            if (out_valid && !prev_ov && q.size() > 0)
                check("latency", longint'(ncyc - acc_time), longint'(q[0].lat));
            if (out_valid && prev_ov && !prev_or) begin
                check("hold_out_p", longint'($signed(out_p)), longint'($signed(prev_p)));
                check("hold_in_ready", longint'(in_ready), 0);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", $signed(out_p));
                end else begin
                    e = q.pop_front();
                    check("product", longint'($signed(out_p)), e.p);
                end
            end
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_p  = out_p;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int n;
        exp_t x;
        n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            x.p   = model_prod(sx(a), sx(b));
            x.lat = model_lat(sx(b));
            q.push_back(x);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            check("drain_timeout", longint'(q.size()), 0);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 25'h1000000;
            1:       v = 25'h0FFFFFF;
            2:       v = W'(32'($urandom_range(0, 15)) - 32'd8);
            3:       v = W'(32'($urandom_range(0, 1023)) - 32'd512);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        bit saw;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_out_p", longint'(out_p), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3 * 5
        send(25'd3, 25'd5, 1'b1);
        check("run_busy", longint'(busy), 1);
        check("run_in_ready", longint'(in_ready), 0);
        drain();

        // most negative squared: exercises -2A width
        send(25'h1000000, 25'h1000000, 1'b1);
        drain();

        // held output with a stray in_valid pulse during DONE
        rdy_mode  = 2;
        man_ready = 1'b0;
        send(-25'sd7, 25'd12345, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_reached_done", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_a     = 25'd1;
                in_b     = 25'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        man_ready = 1'b1;
        drain();
        rdy_mode = 0;

        // reset during RUN cycle 6 (B large so the op is still running)
        send(25'd5, 25'h0ABCDEF, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_busy", longint'(busy), 0);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_valid", longint'(saw), 0);
        send(25'd2, 25'd2, 1'b1);
        drain();

        // early-termination boundaries (full latency when disabled)
        send(25'd1234, 25'd0, 1'b1);
        drain();
        send(-25'sd999, -25'sd1, 1'b1);
        drain();
        send(25'h0FFFFFF, 25'd1, 1'b1);
        drain();
        send(-25'sd3, 25'h0800000, 1'b1);
        drain();

        // back-to-back random traffic with random out_ready
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send(rnd_operand(), rnd_operand(), 1'b1);
        end
        drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
